// File: rtl/bdd_mem_pkg.sv
// Shared definitions for the BDD accelerator node-table memory path.
// Holds default geometry of the node-table SRAM, the requester count,
// fixed requester indices and a small round-robin helper.
package bdd_mem_pkg;

    localparam int DEF_NUM_REQ    = 2;
    localparam int DEF_ADDR_WIDTH = 3;
    localparam int DEF_DATA_WIDTH = 34;
    localparam int DEF_DEPTH      = 8;

    // Fixed requester slots on the arbiter.
    localparam int REQ_BUILDER  = 0;
    localparam int REQ_TRAVERSE = 1;

    // Index that follows a winner in round-robin order.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req     - request vector, one bit per requester
//   ptr     - highest-priority index; search starts here and wraps upward
//   gnt     - one-hot grant (all zero when no request)
//   gnt_idx - binary index of the granted requester (0 when no grant)
// The pointer register is owned by the instantiating module.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx
);

    always_comb begin
        int   idx;
        logic found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/bdd_sram_arbiter.sv
// Node-table SRAM arbiter for the BDD accelerator.
// Shares one SRAM write port (A) and one registered read port (B) between
// NUM_REQ requesters. Each port has its own round-robin lane, so one write
// and one read can be granted in the same cycle.
// Ports:
//   clk, rst_n             - clock, asynchronous active-low reset
//   req_valid/we/addr/wdata - per-requester request (addr/wdata flattened)
//   req_ready              - grant, valid & ready completes the handshake
//   resp_valid/resp_rdata  - one-hot read response, one cycle after grant
//   sram_we_a/addr_a/data_a - SRAM write port
//   sram_addr_b/sram_q_b    - SRAM read port, q_b registered inside the SRAM
module bdd_sram_arbiter
    import bdd_mem_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             resp_valid,
    output logic [DATA_WIDTH-1:0]          resp_rdata,
    output logic                           sram_we_a,
    output logic [ADDR_WIDTH-1:0]          sram_addr_a,
    output logic [DATA_WIDTH-1:0]          sram_data_a,
    output logic [ADDR_WIDTH-1:0]          sram_addr_b,
    input  logic [DATA_WIDTH-1:0]          sram_q_b
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (DEPTH != (1 << ADDR_WIDTH)) begin : g_depth_check
        $error("bdd_sram_arbiter: DEPTH must equal 2**ADDR_WIDTH");
    end

    logic [NUM_REQ-1:0]    wr_cand, rd_cand, wr_gnt, rd_gnt;
    logic [IDX_W-1:0]      wr_idx, rd_idx;
    logic                  wr_any, rd_any;

    logic [IDX_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [IDX_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [IDX_W-1:0]      resp_owner_q, resp_owner_d;
    logic                  rd_pend_q, rd_pend_d;
    logic                  fwd_hit_q, fwd_hit_d;
    logic [DATA_WIDTH-1:0] fwd_data_q, fwd_data_d;

    // Masking candidates with rst_n keeps req_ready low and the SRAM
    // write enable quiet while the block is held in reset.
    assign wr_cand = {NUM_REQ{rst_n}} & req_valid &  req_we;
    assign rd_cand = {NUM_REQ{rst_n}} & req_valid & ~req_we;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_wr_arb (
        .req     (wr_cand),
        .ptr     (wr_ptr_q),
        .gnt     (wr_gnt),
        .gnt_idx (wr_idx)
    );

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rd_arb (
        .req     (rd_cand),
        .ptr     (rd_ptr_q),
        .gnt     (rd_gnt),
        .gnt_idx (rd_idx)
    );

    assign wr_any    = |wr_gnt;
    assign rd_any    = |rd_gnt;
    // Lanes never share a winner: a requester is either writing or reading.
    assign req_ready = wr_gnt | rd_gnt;

    assign sram_we_a   = wr_any;
    assign sram_addr_a = wr_any ? req_addr[wr_idx*ADDR_WIDTH +: ADDR_WIDTH]  : '0;
    assign sram_data_a = wr_any ? req_wdata[wr_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign sram_addr_b = rd_any ? req_addr[rd_idx*ADDR_WIDTH +: ADDR_WIDTH]  : '0;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        resp_owner_d = resp_owner_q;
        rd_pend_d    = rd_any;
        // The SRAM returns the pre-write word on a same-address collision,
        // so the write data is captured and substituted next cycle.
        fwd_hit_d    = wr_any && rd_any && (sram_addr_a == sram_addr_b);
        fwd_data_d   = sram_data_a;
        if (wr_any) wr_ptr_d = IDX_W'(rr_next(int'(wr_idx), NUM_REQ));
        if (rd_any) begin
            rd_ptr_d     = IDX_W'(rr_next(int'(rd_idx), NUM_REQ));
            resp_owner_d = rd_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            resp_owner_q <= '0;
            rd_pend_q    <= 1'b0;
            fwd_hit_q    <= 1'b0;
            fwd_data_q   <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            resp_owner_q <= resp_owner_d;
            rd_pend_q    <= rd_pend_d;
            fwd_hit_q    <= fwd_hit_d;
            fwd_data_q   <= fwd_data_d;
        end
    end

    always_comb begin
        resp_valid = '0;
        if (rd_pend_q) resp_valid[resp_owner_q] = 1'b1;
    end

    assign resp_rdata = !rd_pend_q ? '0 : (fwd_hit_q ? fwd_data_q : sram_q_b);

endmodule

// File: tb/tb_bdd_sram_arbiter.sv
module tb_bdd_sram_arbiter;
    import bdd_mem_pkg::*;

    localparam int N  = 2;
    localparam int AW = 3;
    localparam int DW = 34;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0, req_we = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    req_ready, resp_valid;
    logic [DW-1:0]   resp_rdata, sram_data_a;
    logic            sram_we_a;
    logic [AW-1:0]   sram_addr_a, sram_addr_b;
    logic [DW-1:0]   sram_q_b = '0;

    logic [DW-1:0]   sram_mem [8] = '{default: '0};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bdd_sram_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .sram_we_a(sram_we_a), .sram_addr_a(sram_addr_a), .sram_data_a(sram_data_a),
        .sram_addr_b(sram_addr_b), .sram_q_b(sram_q_b)
    );

    // Behavioural SRAM: write port A, registered read port B (old data on collision).
    always @(posedge clk) begin
        if (sram_we_a) sram_mem[sram_addr_a] <= sram_data_a;
        sram_q_b <= sram_mem[sram_addr_b];
    end

    // ---------------- reference model ----------------
    int            m_wptr = 0, m_rptr = 0, m_rown = 0;
    bit            m_rv = 0;
    logic [DW-1:0] m_rdata = '0;
    logic [DW-1:0] m_mem [8] = '{default: '0};
    int            e_wi, e_ri;
    logic [N-1:0]  e_ready, e_rv;
    logic          e_we;
    logic [AW-1:0] e_addr_a, e_addr_b;
    logic [DW-1:0] e_data_a, e_rdata;

    task automatic model_reset();
        m_wptr = 0; m_rptr = 0; m_rv = 0;
    endtask

    // Expected combinational view for the current inputs and model state.
    task automatic model_eval();
        e_wi = -1; e_ri = -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_wptr + k) % N;
            if (e_wi < 0 && rst_n && req_valid[i] && req_we[i]) e_wi = i;
            i = (m_rptr + k) % N;
            if (e_ri < 0 && rst_n && req_valid[i] && !req_we[i]) e_ri = i;
        end
        e_ready = '0; e_we = 0; e_addr_a = '0; e_data_a = '0; e_addr_b = '0;
        if (e_wi >= 0) begin
            e_ready[e_wi] = 1'b1; e_we = 1'b1;
            e_addr_a = req_addr[e_wi*AW +: AW];
            e_data_a = req_wdata[e_wi*DW +: DW];
        end
        if (e_ri >= 0) begin
            e_ready[e_ri] = 1'b1;
            e_addr_b = req_addr[e_ri*AW +: AW];
        end
        e_rv = '0;
        if (m_rv) e_rv[m_rown] = 1'b1;
        e_rdata = m_rv ? m_rdata : '0;
    endtask

    // A read observes the memory including a same-cycle write.
    task automatic model_clk();
        if (!rst_n) model_reset();
        else begin
            if (e_wi >= 0) begin
                m_mem[e_addr_a] = e_data_a;
                m_wptr = (e_wi + 1) % N;
            end
            if (e_ri >= 0) begin
                m_rv = 1; m_rown = e_ri; m_rdata = m_mem[e_addr_b];
                m_rptr = (e_ri + 1) % N;
            end else m_rv = 0;
        end
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        model_clk();
        @(negedge clk);
    endtask

    task automatic clear_req();
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    endtask

    task automatic set_req(input int i, input logic we, input int addr, input logic [DW-1:0] d);
        req_valid[i] = 1'b1; req_we[i] = we;
        req_addr[i*AW +: AW] = AW'(addr);
        req_wdata[i*DW +: DW] = d;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 0; model_reset(); clear_req();
        set_req(REQ_BUILDER, 1'b1, 2, 34'h5);
        @(negedge clk); #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_ready got=%b exp=00", req_ready); end
        checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL rst_resp_valid got=%b exp=00", resp_valid); end
        checks++; if (sram_we_a !== 1'b0) begin errors++; $display("FAIL rst_we_a got=%b exp=0", sram_we_a); end
        checks++; if (resp_rdata !== '0) begin errors++; $display("FAIL rst_rdata got=%h exp=0", resp_rdata); end
        clear_req();
        @(negedge clk); rst_n = 1; #1;
        checks++; if (req_ready !== 2'b00 || resp_valid !== 2'b00 || sram_we_a !== 1'b0) begin
            errors++; $display("FAIL idle got ready=%b resp=%b we=%b exp 00/00/0", req_ready, resp_valid, sram_we_a);
        end
        tick();
    endtask

    task automatic test_write_then_read();
        clear_req(); set_req(REQ_BUILDER, 1'b1, 3, 34'h0_DEAD_BEEF); #1;
        checks++; if (req_ready !== 2'b01 || sram_we_a !== 1'b1 || sram_addr_a !== 3'd3 || sram_data_a !== 34'h0_DEAD_BEEF) begin
            errors++; $display("FAIL wr_grant got ready=%b we=%b addr=%0d data=%h exp 01/1/3/0deadbeef", req_ready, sram_we_a, sram_addr_a, sram_data_a);
        end
        tick();
        clear_req(); set_req(REQ_TRAVERSE, 1'b0, 3, '0); #1;
        checks++; if (req_ready !== 2'b10 || sram_addr_b !== 3'd3 || sram_we_a !== 1'b0) begin
            errors++; $display("FAIL rd_grant got ready=%b addr_b=%0d we=%b exp 10/3/0", req_ready, sram_addr_b, sram_we_a);
        end
        tick();
        clear_req(); #1;
        checks++; if (resp_valid !== 2'b10 || resp_rdata !== 34'h0_DEAD_BEEF) begin
            errors++; $display("FAIL rd_resp got valid=%b data=%h exp 10/0deadbeef", resp_valid, resp_rdata);
        end
        tick();
    endtask

    task automatic test_read_alternate();
        logic [DW-1:0] d1, d2;
        d1 = 34'h1_1111_1111; d2 = 34'h2_2222_2222;
        clear_req(); set_req(REQ_TRAVERSE, 1'b1, 1, d1); tick();
        clear_req(); set_req(REQ_BUILDER, 1'b1, 2, d2); tick();
        // Make the read lane start from requester 0.
        clear_req(); set_req(REQ_TRAVERSE, 1'b0, 7, '0); tick();
        for (int c = 0; c < 6; c++) begin
            clear_req();
            if (c < 5) begin
                set_req(0, 1'b0, 1, '0);
                set_req(1, 1'b0, 2, '0);
            end
            #1;
            if (c < 5) begin
                checks++;
                if (req_ready !== ((c % 2 == 0) ? 2'b01 : 2'b10)) begin
                    errors++; $display("FAIL alt_ready c=%0d got=%b exp=%b", c, req_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
                end
            end
            if (c > 0) begin
                checks++;
                if (resp_valid !== (((c - 1) % 2 == 0) ? 2'b01 : 2'b10) || resp_rdata !== (((c - 1) % 2 == 0) ? d1 : d2)) begin
                    errors++; $display("FAIL alt_resp c=%0d got valid=%b data=%h", c, resp_valid, resp_rdata);
                end
            end
            tick();
        end
    endtask

    task automatic test_collision();
        clear_req();
        set_req(REQ_BUILDER, 1'b1, 5, 34'h1_2345_6789);
        set_req(REQ_TRAVERSE, 1'b0, 5, '0);
        #1;
        checks++; if (req_ready !== 2'b11 || sram_addr_a !== 3'd5 || sram_addr_b !== 3'd5) begin
            errors++; $display("FAIL col_ready got ready=%b a=%0d b=%0d exp 11/5/5", req_ready, sram_addr_a, sram_addr_b);
        end
        tick();
        clear_req(); #1;
        checks++; if (resp_valid !== 2'b10 || resp_rdata !== 34'h1_2345_6789) begin
            errors++; $display("FAIL col_fwd got valid=%b data=%h exp 10/123456789", resp_valid, resp_rdata);
        end
        tick();
    endtask

    task automatic test_write_contention();
        // Bring the write lane back to requester 0 first.
        clear_req(); set_req(REQ_TRAVERSE, 1'b1, 6, 34'h66); tick();
        clear_req(); set_req(0, 1'b1, 4, 34'hA); set_req(1, 1'b1, 4, 34'hB); #1;
        checks++; if (req_ready !== 2'b01 || sram_data_a !== 34'hA) begin
            errors++; $display("FAIL wc_first got ready=%b data=%h exp 01/a", req_ready, sram_data_a);
        end
        tick();
        clear_req(); set_req(1, 1'b1, 4, 34'hB); #1;
        checks++; if (req_ready !== 2'b10 || sram_data_a !== 34'hB) begin
            errors++; $display("FAIL wc_second got ready=%b data=%h exp 10/b", req_ready, sram_data_a);
        end
        tick();
        clear_req(); set_req(0, 1'b0, 4, '0); tick();
        clear_req(); #1;
        checks++; if (resp_valid !== 2'b01 || resp_rdata !== 34'hB) begin
            errors++; $display("FAIL wc_read got valid=%b data=%h exp 01/b", resp_valid, resp_rdata);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        // Leave both pointers at 1 so the reset has something to clear.
        clear_req(); set_req(0, 1'b1, 7, 34'h77); tick();
        clear_req(); set_req(0, 1'b0, 0, '0); tick();
        clear_req(); set_req(0, 1'b0, 4, '0); set_req(1, 1'b0, 4, '0); #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL rm_grant got=%b exp=10", req_ready); end
        model_eval();
        @(posedge clk); model_clk();
        #1 rst_n = 0; model_reset();
        #1;
        checks++; if (resp_valid !== 2'b00 || resp_rdata !== '0 || req_ready !== 2'b00) begin
            errors++; $display("FAIL rm_drop got valid=%b data=%h ready=%b exp 00/0/00", resp_valid, resp_rdata, req_ready);
        end
        @(negedge clk); tick();
        rst_n = 1;
        clear_req(); set_req(0, 1'b0, 1, '0); set_req(1, 1'b0, 2, '0); #1;
        checks++; if (req_ready !== 2'b01 || resp_valid !== 2'b00) begin
            errors++; $display("FAIL rm_rd_ptr got ready=%b resp=%b exp 01/00", req_ready, resp_valid);
        end
        tick();
        clear_req(); set_req(0, 1'b1, 0, 34'h1); set_req(1, 1'b1, 0, 34'h2); #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rm_wr_ptr got=%b exp=01", req_ready); end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            clear_req();
            for (int i = 0; i < N; i++) begin
                logic [63:0] r;
                r = {$urandom, $urandom};
                if ($urandom_range(0, 3) != 0)
                    set_req(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), r[DW-1:0]);
            end
            #1;
            model_eval();
            checks++; if (req_ready !== e_ready) begin
                errors++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, req_ready, e_ready);
            end
            checks++; if (sram_we_a !== e_we || sram_addr_a !== e_addr_a || sram_data_a !== e_data_a) begin
                errors++; $display("FAIL rnd_port_a c=%0d got %b/%0d/%h exp %b/%0d/%h", c, sram_we_a, sram_addr_a, sram_data_a, e_we, e_addr_a, e_data_a);
            end
            checks++; if (sram_addr_b !== e_addr_b) begin
                errors++; $display("FAIL rnd_addr_b c=%0d got=%0d exp=%0d", c, sram_addr_b, e_addr_b);
            end
            checks++; if (resp_valid !== e_rv || resp_rdata !== e_rdata) begin
                errors++; $display("FAIL rnd_resp c=%0d got %b/%h exp %b/%h", c, resp_valid, resp_rdata, e_rv, e_rdata);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_write_then_read();
        test_read_alternate();
        test_collision();
        test_write_contention();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bdd_sram_arbiter.md
Name: bdd_sram_arbiter

Overview:
- Shares the node-table SRAM (one write port A, one registered read port B) between NUM_REQ requesters in the BDD accelerator, e.g. node builder, unique-table lookup and traversal engine.
- Grants at most one write and one read per cycle, each lane by independent round-robin.
- Returns read data to the issuing requester one cycle after grant.
- Forwards write data when a read and a write hit the same address in the same cycle.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- ADDR_WIDTH, 3, SRAM address width.
- DATA_WIDTH, 34, SRAM word width.
- DEPTH, 8, SRAM entries; must equal 2**ADDR_WIDTH.

Ports:
- clk  in  1  single clock; all state on posedge clk.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_we  in  NUM_REQ  per-requester: 1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i at slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data.
- req_ready  out  NUM_REQ  one-hot-per-lane grant; handshake completes when valid & ready.
- resp_valid  out  NUM_REQ  one-hot read-response strobe.
- resp_rdata  out  DATA_WIDTH  read data, valid when any resp_valid bit is set.
- sram_we_a  out  1  to SRAM we_a.
- sram_addr_a  out  ADDR_WIDTH  to SRAM addr_a.
- sram_data_a  out  DATA_WIDTH  to SRAM data_a.
- sram_addr_b  out  ADDR_WIDTH  to SRAM addr_b.
- sram_q_b  in  DATA_WIDTH  from SRAM q_b; registered, valid the cycle after addr_b is presented.

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - wr_ptr = 0 and rd_ptr = 0.
  - resp_valid = 0, fwd_hit = 0, resp_owner = 0.
  - resp_rdata = 0.
  - Combinational outputs follow from req_* inputs even during reset. req_ready is forced 0 while rst_n = 0.
- Lane split:
  - Write candidates: valid & we.
  - Read candidates: valid & ~we.
  - A requester holds one request per cycle, so the write grant and the read grant never go to the same requester.
- Round-robin, per lane:
  - Search from that lane's pointer upward, wrapping modulo NUM_REQ.
  - The first candidate found is granted and gets req_ready = 1 in the same cycle; the grant is combinational from req_valid.
  - On a grant to requester i, the lane pointer becomes (i+1) mod NUM_REQ at the next edge.
  - No grant leaves the pointer unchanged.
- Write lane:
  - Granted write drives sram_we_a = 1, sram_addr_a and sram_data_a from the winner.
  - With no write grant: sram_we_a = 0; addr_a/data_a = 0.
- Read lane:
  - The granted read drives sram_addr_b from the winner.
  - With no read grant, sram_addr_b = 0 and no response is issued.
- Read latency is exactly 1:
  - A read granted in cycle t gives resp_valid[i] = 1 in cycle t+1, from registered owner state.
  - resp_rdata = sram_q_b in cycle t+1.
  - resp_valid is a 1-cycle pulse; a back-to-back read from the same requester produces consecutive pulses.
- Same-cycle collision (write granted to addr X and read granted to addr X in cycle t):
  - The SRAM returns the old word, so the write data is registered.
  - In t+1, resp_rdata equals the forwarded write data instead of sram_q_b.
- Write at t, read of the same address at t+1: no forwarding needed; the SRAM already holds the new word.
- Two writes from different requesters to the same address: serialized by round-robin; the last granted one wins.
- Reset asserted mid-operation: any pending response is dropped (resp_valid = 0) and both pointers return to 0.
- Throughput: one write plus one read per cycle.
- Starvation bound: a held request is granted within NUM_REQ cycles on its lane.

Decomposition:
- Shared package bdd_mem_pkg holds:
  - ADDR_WIDTH, DATA_WIDTH, DEPTH defaults.
  - NUM_REQ default.
  - Requester-index constants (REQ_BUILDER = 0, REQ_TRAVERSE = 1).
- Sub-module rr_arbiter (NUM_REQ):
  - Ports: req vector, pointer, one-hot grant, grant index.
  - Instantiated twice, once for the write lane and once for the read lane.
  - Pointer registers live in the parent.

Test Plan:
- Reset, then idle with no req_valid:
  - req_ready = 00, resp_valid = 00, sram_we_a = 0.
  - After release, pointers = 0.
- Req0 writes addr 3 = 34'h0_DEAD_BEEF at t; req1 reads addr 3 at t+1:
  - ready0 = 1 at t, with sram_we_a = 1, addr_a = 3.
  - resp_valid = 10 at t+2, resp_rdata = 34'h0DEADBEEF.
- Both requesters read continuously (req0 addr 1, req1 addr 2):
  - Grants alternate 01, 10, 01, 10.
  - resp_valid pulses alternate one cycle later with the matching data.
- Same cycle: req0 writes addr 5 = 34'h1_2345_6789 and req1 reads addr 5 (old value 0):
  - Both ready = 1.
  - Next cycle: resp_valid = 10, resp_rdata = 34'h123456789 (forwarded).
- Both requesters write simultaneously: req0 addr 4 = 34'hA, req1 addr 4 = 34'hB, each held until granted:
  - req0 is granted first, req1 next cycle.
  - A subsequent read of addr 4 returns 34'hB.
- Req1 read granted at t; rst_n pulled low between t and t+1:
  - resp_valid stays 0, no response is emitted.
  - After release, req0 wins the first contested read.
